bus_addr_dec: RTL and testbench



---
 rtl/bus_pkg.sv | 30 +++
 rtl/bus_region_match.sv | 31 +++
 rtl/bus_addr_dec.sv | 102 ++++++++++
 tb/tb_bus_addr_dec.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the system bus address decoder: state codes,
// default geometry and the default slave region map.
package bus_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERR    = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  localparam int DEF_AW = 8;
  localparam int DEF_NS = 5;

  typedef struct packed {
    logic [DEF_AW-1:0] base;
    logic [DEF_AW-1:0] limit;
  } region_t;

  // Half-open windows [base, limit), listed in slave index order 0..4
  localparam region_t DMAC  = '{base: 8'h00, limit: 8'h10};
  localparam region_t MUL   = '{base: 8'h10, limit: 8'h20};
  localparam region_t RAM_A = '{base: 8'h20, limit: 8'h40};
  localparam region_t RAM_B = '{base: 8'h40, limit: 8'h60};
  localparam region_t RAM_R = '{base: 8'h60, limit: 8'h80};

  localparam logic [DEF_NS*DEF_AW-1:0] DEF_BASE =
    {RAM_R.base, RAM_B.base, RAM_A.base, MUL.base, DMAC.base};
  localparam logic [DEF_NS*DEF_AW-1:0] DEF_LIMIT =
    {RAM_R.limit, RAM_B.limit, RAM_A.limit, MUL.limit, DMAC.limit};

endpackage

// File: rtl/bus_region_match.sv
// Combinational window match: per-slave hit vector, lowest-index one-hot
// winner and a miss flag.
module bus_region_match
  import bus_pkg::*;
#(
  parameter int                 AW    = DEF_AW,
  parameter int                 NS    = DEF_NS,
  parameter logic [NS*AW-1:0]   BASE  = DEF_BASE,
  parameter logic [NS*AW-1:0]   LIMIT = DEF_LIMIT
) (
  input  logic [AW-1:0] address,
  output logic [NS-1:0] hit,
  output logic [NS-1:0] sel,
  output logic          miss
);

  for (genvar i = 0; i < NS; i++) begin : g_win
    logic [AW-1:0] win_base;
    logic [AW-1:0] win_limit;
    assign win_base  = BASE[i*AW +: AW];
    assign win_limit = LIMIT[i*AW +: AW];
    // An empty or inverted window can never hit
    assign hit[i] = (win_base < win_limit) && !(address < win_base) &&
                    (address < win_limit);
  end

  // Isolating the lowest set bit gives the priority winner directly
  assign sel  = hit & (~hit + NS'(1));
  assign miss = ~|hit;

endmodule

// File: rtl/bus_addr_dec.sv
// Registered slave-select decoder with decode-error pulse, error address
// capture and saturating miss counter.
//
// state  | meaning
// IDLE   | sampling m_req/m_address, s_sel = 0
// ACTIVE | slave selected, s_sel held until m_req falls
// ERR    | one-cycle decode error, error registers update on exit
// WAIT   | rest of an unmapped transaction, waiting for m_req low
module bus_addr_dec
  import bus_pkg::*;
#(
  parameter int                 AW    = DEF_AW,
  parameter int                 NS    = DEF_NS,
  parameter logic [NS*AW-1:0]   BASE  = DEF_BASE,
  parameter logic [NS*AW-1:0]   LIMIT = DEF_LIMIT,
  parameter int                 CW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m_req,
  input  logic [AW-1:0] m_address,
  input  logic          err_clr,
  output logic [NS-1:0] s_sel,
  output logic          dec_err,
  output logic          dec_busy,
  output logic [AW-1:0] err_addr,
  output logic [CW-1:0] err_cnt
);

  logic [1:0]    state;
  logic [AW-1:0] cap_addr;
  logic [NS-1:0] match_hit;
  logic [NS-1:0] match_sel;
  logic          match_miss;

  bus_region_match #(
    .AW    (AW),
    .NS    (NS),
    .BASE  (BASE),
    .LIMIT (LIMIT)
  ) u_match (
    .address (m_address),
    .hit     (match_hit),
    .sel     (match_sel),
    .miss    (match_miss)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      s_sel    <= '0;
      cap_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_req) begin
            cap_addr <= m_address;
            if (match_miss) begin
              state <= ERR;
            end else begin
              state <= ACTIVE;
              s_sel <= match_sel;
            end
          end
        end
        ACTIVE: begin
          if (!m_req) begin
            state <= IDLE;
            s_sel <= '0;
          end
        end
        ERR:     state <= m_req ? WAIT : IDLE;
        WAIT:    if (!m_req) state <= IDLE;
        default: begin
          state <= IDLE;
          s_sel <= '0;
        end
      endcase
    end
  end

  // Clear wins over a simultaneous error update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (err_clr) begin
      err_addr <= '0;
      err_cnt  <= '0;
    end else if (state == ERR) begin
      err_addr <= cap_addr;
      if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
    end
  end

  assign dec_err  = (state == ERR);
  assign dec_busy = (state != IDLE);

  logic unused_hit;
  assign unused_hit = ^match_hit;

endmodule

// File: tb/tb_bus_addr_dec.sv
// Directed self-checking bench for bus_addr_dec, including a second
// instance with an overlapping region map.
module tb_bus_addr_dec;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_req = 1'b0;
  logic [7:0] m_address = 8'h00;
  logic       err_clr = 1'b0;

  logic [4:0] s_sel;
  logic       dec_err;
  logic       dec_busy;
  logic [7:0] err_addr;
  logic [7:0] err_cnt;

  logic [4:0] o_sel;
  logic       o_err;
  logic       o_busy;
  logic [7:0] o_err_addr;
  logic [7:0] o_err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_addr_dec dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_req     (m_req),
    .m_address (m_address),
    .err_clr   (err_clr),
    .s_sel     (s_sel),
    .dec_err   (dec_err),
    .dec_busy  (dec_busy),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt)
  );

  bus_addr_dec #(
    .BASE ({8'h60, 8'h40, 8'h20, 8'h08, 8'h00})
  ) u_ovl (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_req     (m_req),
    .m_address (m_address),
    .err_clr   (err_clr),
    .s_sel     (o_sel),
    .dec_err   (o_err),
    .dec_busy  (o_busy),
    .err_addr  (o_err_addr),
    .err_cnt   (o_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bnd_addr [6] = '{8'h0F, 8'h10, 8'h3F, 8'h40, 8'h7F, 8'h80};
  logic [4:0] bnd_sel  [6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};

  initial begin
    #12;
    chk("rst_sel", s_sel, 0);
    chk("rst_err", dec_err, 0);
    chk("rst_busy", dec_busy, 0);
    chk("rst_eaddr", err_addr, 0);
    chk("rst_ecnt", err_cnt, 0);
    reset_n = 1'b1;

    // Hit on slave 1, held three cycles
    m_address = 8'h15; m_req = 1'b1;
    step(); chk("hit_sel0", s_sel, 5'b00010); chk("hit_busy", dec_busy, 1);
    chk("hit_noerr", dec_err, 0);
    step(); chk("hit_sel1", s_sel, 5'b00010);
    step(); chk("hit_sel2", s_sel, 5'b00010);
    m_req = 1'b0;
    step(); chk("rel_sel", s_sel, 0); chk("rel_busy", dec_busy, 0);

    // Miss with request held
    m_address = 8'h9A; m_req = 1'b1;
    step(); chk("miss_err", dec_err, 1); chk("miss_sel", s_sel, 0);
    chk("miss_busy", dec_busy, 1); chk("miss_cnt_pre", err_cnt, 0);
    m_address = 8'h11;
    step(); chk("miss_err_end", dec_err, 0); chk("miss_eaddr", err_addr, 8'h9A);
    chk("miss_cnt", err_cnt, 1); chk("wait_busy", dec_busy, 1); chk("wait_sel", s_sel, 0);
    step(); chk("wait_busy2", dec_busy, 1); chk("wait_err2", dec_err, 0);
    m_req = 1'b0;
    step(); chk("wait_rel", dec_busy, 0);

    // Window boundaries; the 8'h80 miss takes err_cnt to 2
    for (int i = 0; i < 6; i++) begin
      m_address = bnd_addr[i]; m_req = 1'b1;
      step();
      chk($sformatf("bnd_sel_%0h", bnd_addr[i]), s_sel, bnd_sel[i]);
      chk($sformatf("bnd_err_%0h", bnd_addr[i]), dec_err, (bnd_sel[i] == 5'b0) ? 1 : 0);
      m_req = 1'b0;
      step();
      chk($sformatf("bnd_idle_%0h", bnd_addr[i]), dec_busy, 0);
    end
    chk("bnd_cnt", err_cnt, 2);
    chk("bnd_eaddr", err_addr, 8'h80);

    // Address change mid-transaction is ignored
    m_address = 8'h22; m_req = 1'b1;
    step(); chk("hold_sel0", s_sel, 5'b00100);
    m_address = 8'h70;
    step(); chk("hold_sel1", s_sel, 5'b00100);
    step(); chk("hold_sel2", s_sel, 5'b00100);
    m_req = 1'b0;
    step(); chk("hold_rel", s_sel, 0);

    // Saturation: 2 + 252 = 254, then 255, then stays 255 (300 misses in total)
    for (int i = 0; i < 252; i++) begin
      m_address = 8'h90; m_req = 1'b1; step();
      m_req = 1'b0; step();
    end
    chk("sat_254", err_cnt, 254);
    m_address = 8'hB7; m_req = 1'b1; step(); m_req = 1'b0; step();
    chk("sat_255", err_cnt, 255);
    for (int i = 0; i < 47; i++) begin
      m_address = 8'hC3; m_req = 1'b1; step();
      m_req = 1'b0; step();
    end
    chk("sat_hold", err_cnt, 255);
    chk("sat_eaddr", err_addr, 8'hC3);

    // Clear on an error cycle beats the increment
    m_address = 8'hF0; m_req = 1'b1;
    step(); chk("clr_in_err", dec_err, 1);
    err_clr = 1'b1; m_req = 1'b0;
    step(); chk("clr_cnt", err_cnt, 0); chk("clr_eaddr", err_addr, 0);
    err_clr = 1'b0;

    // Async reset during ACTIVE, request still high afterwards
    m_address = 8'h30; m_req = 1'b1;
    step(); chk("ract_sel", s_sel, 5'b00100);
    #1 reset_n = 1'b0;
    #1 chk("ract_sel_rst", s_sel, 0); chk("ract_busy_rst", dec_busy, 0);
    #1 reset_n = 1'b1;
    step(); chk("ract_redecode", s_sel, 5'b00100);
    m_req = 1'b0;
    step();

    // Async reset during ERR
    m_address = 8'h9A; m_req = 1'b1;
    step(); m_req = 1'b0; step();
    chk("rerr_cnt_pre", err_cnt, 1);
    m_address = 8'hE1; m_req = 1'b1;
    step(); chk("rerr_err", dec_err, 1);
    #1 reset_n = 1'b0;
    #1 chk("rerr_err_rst", dec_err, 0); chk("rerr_cnt_rst", err_cnt, 0);
    chk("rerr_eaddr_rst", err_addr, 0);
    m_req = 1'b0;
    #1 reset_n = 1'b1;
    step();

    // Overlapping map: lowest index wins
    m_address = 8'h0C; m_req = 1'b1;
    step(); chk("ovl_0c", o_sel, 5'b00001); chk("def_0c", s_sel, 5'b00001);
    m_req = 1'b0; step();
    m_address = 8'h1C; m_req = 1'b1;
    step(); chk("ovl_1c", o_sel, 5'b00010);
    m_req = 1'b0; step();
    chk("ovl_idle", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
